// File: rtl/hci_mem_bank_adapter.sv
// HCI target channel to single SRAM/SCM bank macro: pin mapping, latency-matched response
// pipeline and idle sleep/wake FSM. Optional output register: HCI_BANK_ADAPTER_RDATA_REG_EN.
module hci_mem_bank_adapter #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 10,
    parameter int unsigned IW          = 8,
    parameter int unsigned UW          = 2,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic [AW-1:0]   add_i,
    input  logic            wen_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [DW-1:0]   data_i,
    input  logic [IW-1:0]   id_i,
    input  logic [UW-1:0]   user_i,
    output logic            r_valid_o,
    output logic [DW-1:0]   r_data_o,
    output logic [IW-1:0]   r_id_o,
    output logic [UW-1:0]   r_user_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            mem_sleep_o
);

    localparam int unsigned    ICW       = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [ICW-1:0] IDLE_LAST = (IDLE_CYCLES > 0) ? ICW'(IDLE_CYCLES - 1) : '0;
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYCLES);
    localparam logic [3:0]     WAKE_LOAD = 4'(WAKE_CYCLES);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

    state_e                         state_r;
    logic [ICW-1:0]                 idle_cnt_r;
    logic [3:0]                     wake_cnt_r;
    logic                           sleep_r;

    logic [MEM_LATENCY-1:0]         pipe_valid_r;
    logic [MEM_LATENCY-1:0]         pipe_read_r;
    logic [MEM_LATENCY-1:0][IW-1:0] pipe_id_r;
    logic [MEM_LATENCY-1:0][UW-1:0] pipe_user_r;

    logic                           gnt_s;
    logic                           accept_s;
    logic                           busy_s;
    logic                           idle_inc_s;
    logic                           fin_valid_s;
    logic                           rsp_valid_s;
    logic [DW-1:0]                  rsp_data_s;
    logic [IW-1:0]                  rsp_id_s;
    logic [UW-1:0]                  rsp_user_s;

    // Grant depends only on FSM state, so there is no path from req_i to gnt_o.
    assign gnt_s       = (state_r == ST_ACTIVE);
    assign gnt_o       = gnt_s;
    assign accept_s    = req_i & gnt_s;
    assign mem_sleep_o = sleep_r;
    assign idle_inc_s  = ~req_i & ~busy_s;

    // Macro pin mapping; byte enables are quiet whenever the macro is not selected.
    always_comb begin
        mem_req_o   = accept_s;
        mem_we_o    = ~wen_i;
        mem_addr_o  = add_i;
        mem_wdata_o = data_i;
        mem_be_o    = '0;
        if (accept_s) begin
            mem_be_o = be_i;
        end else begin
            mem_be_o = '0;
        end
    end

    // Response pipeline: one stage per macro latency cycle; clear drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_r <= '0;
            pipe_read_r  <= '0;
            pipe_id_r    <= '0;
            pipe_user_r  <= '0;
        end else if (clear_i) begin
            pipe_valid_r <= '0;
            pipe_read_r  <= '0;
            pipe_id_r    <= '0;
            pipe_user_r  <= '0;
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_read_r[0]  <= accept_s & wen_i;
            pipe_id_r[0]    <= accept_s ? id_i : '0;
            pipe_user_r[0]  <= accept_s ? user_i : '0;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_read_r[i]  <= pipe_read_r[i-1];
                pipe_id_r[i]    <= pipe_id_r[i-1];
                pipe_user_r[i]  <= pipe_user_r[i-1];
            end
        end
    end

    assign fin_valid_s = pipe_valid_r[MEM_LATENCY-1];

    // Final-stage response; all fields are zero when not valid, data only for reads.
    always_comb begin
        rsp_valid_s = fin_valid_s;
        rsp_data_s  = '0;
        rsp_id_s    = '0;
        rsp_user_s  = '0;
        if (fin_valid_s) begin
            rsp_id_s   = pipe_id_r[MEM_LATENCY-1];
            rsp_user_s = pipe_user_r[MEM_LATENCY-1];
            if (pipe_read_r[MEM_LATENCY-1]) begin
                rsp_data_s = mem_rdata_i;
            end else begin
                rsp_data_s = '0;
            end
        end else begin
            rsp_id_s   = '0;
            rsp_user_s = '0;
            rsp_data_s = '0;
        end
    end

`ifdef HCI_BANK_ADAPTER_RDATA_REG_EN
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic [IW-1:0] out_id_r;
    logic [UW-1:0] out_user_r;

    // Extra response register; counts as in-flight for idle detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= '0;
            out_user_r  <= '0;
        end else if (clear_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= '0;
            out_user_r  <= '0;
        end else begin
            out_valid_r <= rsp_valid_s;
            out_data_r  <= rsp_data_s;
            out_id_r    <= rsp_id_s;
            out_user_r  <= rsp_user_s;
        end
    end

    assign r_valid_o = out_valid_r;
    assign r_data_o  = out_data_r;
    assign r_id_o    = out_id_r;
    assign r_user_o  = out_user_r;
    assign busy_s    = (|pipe_valid_r) | out_valid_r;
`else
    assign r_valid_o = rsp_valid_s;
    assign r_data_o  = rsp_data_s;
    assign r_id_o    = rsp_id_s;
    assign r_user_o  = rsp_user_s;
    assign busy_s    = |pipe_valid_r;
`endif

    // Sleep/wake FSM with idle and wake counters and registered sleep pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_ACTIVE;
            idle_cnt_r <= '0;
            wake_cnt_r <= 4'd0;
            sleep_r    <= 1'b0;
        end else if (clear_i) begin
            state_r    <= ST_ACTIVE;
            idle_cnt_r <= '0;
            wake_cnt_r <= 4'd0;
            sleep_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_ACTIVE: begin
                    sleep_r    <= 1'b0;
                    wake_cnt_r <= 4'd0;
                    if (accept_s) begin
                        idle_cnt_r <= '0;
                    end else if (idle_inc_s) begin
                        // Pipeline is empty here, so sleep never strands a response.
                        if ((IDLE_CYCLES != 0) && (idle_cnt_r == IDLE_LAST)) begin
                            state_r    <= ST_SLEEP;
                            sleep_r    <= 1'b1;
                            idle_cnt_r <= '0;
                        end else if (idle_cnt_r != IDLE_MAX) begin
                            idle_cnt_r <= idle_cnt_r + ICW'(1'b1);
                        end else begin
                            idle_cnt_r <= idle_cnt_r;
                        end
                    end else begin
                        idle_cnt_r <= idle_cnt_r;
                    end
                end
                ST_SLEEP: begin
                    idle_cnt_r <= '0;
                    if (req_i) begin
                        sleep_r <= 1'b0;
                        if (WAKE_CYCLES == 0) begin
                            state_r    <= ST_ACTIVE;
                            wake_cnt_r <= 4'd0;
                        end else begin
                            state_r    <= ST_WAKE;
                            wake_cnt_r <= WAKE_LOAD;
                        end
                    end else begin
                        sleep_r    <= 1'b1;
                        wake_cnt_r <= 4'd0;
                    end
                end
                ST_WAKE: begin
                    sleep_r    <= 1'b0;
                    idle_cnt_r <= '0;
                    if (wake_cnt_r <= 4'd1) begin
                        state_r    <= ST_ACTIVE;
                        wake_cnt_r <= 4'd0;
                    end else begin
                        wake_cnt_r <= wake_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r    <= ST_ACTIVE;
                    idle_cnt_r <= '0;
                    wake_cnt_r <= 4'd0;
                    sleep_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hci_mem_bank_adapter.sv
// Directed bench for hci_mem_bank_adapter: two instances (MEM_LATENCY 1 and 3) sharing stimulus,
// each backed by a simple behavioural bank model.
module tb_hci_mem_bank_adapter;

`ifdef HCI_BANK_ADAPTER_RDATA_REG_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req = 1'b0;
    logic        wen = 1'b1;
    logic [9:0]  add = 10'h0;
    logic [3:0]  be = 4'h0;
    logic [31:0] data = 32'h0;
    logic [7:0]  id = 8'h0;
    logic [1:0]  user = 2'h0;

    logic        gnt1, rv1, mreq1, mwe1, msl1;
    logic [31:0] rd1, mwd1, mrd1;
    logic [7:0]  rid1;
    logic [1:0]  ru1;
    logic [9:0]  maddr1;
    logic [3:0]  mbe1;

    logic        gnt3, rv3, mreq3, mwe3, msl3;
    logic [31:0] rd3, mwd3, mrd3, p1_3, p2_3;
    logic [7:0]  rid3;
    logic [1:0]  ru3;
    logic [9:0]  maddr3;
    logic [3:0]  mbe3;

    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hci_mem_bank_adapter #(.MEM_LATENCY(1), .IDLE_CYCLES(16), .WAKE_CYCLES(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .gnt_o(gnt1),
        .add_i(add), .wen_i(wen), .be_i(be), .data_i(data), .id_i(id), .user_i(user),
        .r_valid_o(rv1), .r_data_o(rd1), .r_id_o(rid1), .r_user_o(ru1),
        .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_addr_o(maddr1), .mem_wdata_o(mwd1),
        .mem_be_o(mbe1), .mem_rdata_i(mrd1), .mem_sleep_o(msl1));

    hci_mem_bank_adapter #(.MEM_LATENCY(3), .IDLE_CYCLES(16), .WAKE_CYCLES(2)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .gnt_o(gnt3),
        .add_i(add), .wen_i(wen), .be_i(be), .data_i(data), .id_i(id), .user_i(user),
        .r_valid_o(rv3), .r_data_o(rd3), .r_id_o(rid3), .r_user_o(ru3),
        .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_wdata_o(mwd3),
        .mem_be_o(mbe3), .mem_rdata_i(mrd3), .mem_sleep_o(msl3));

    // Bank model, 1-cycle read latency.
    always @(posedge clk) begin
        if (mreq1) begin
            if (mwe1) begin
                for (int b = 0; b < 4; b++) begin
                    if (mbe1[b]) mem1[maddr1][8*b +: 8] <= mwd1[8*b +: 8];
                end
            end else begin
                mrd1 <= mem1[maddr1];
            end
        end
    end

    // Bank model, 3-cycle read latency.
    always @(posedge clk) begin
        if (mreq3) begin
            if (mwe3) begin
                for (int b = 0; b < 4; b++) begin
                    if (mbe3[b]) mem3[maddr3][8*b +: 8] <= mwd3[8*b +: 8];
                end
            end else begin
                p1_3 <= mem3[maddr3];
            end
        end
        p2_3 <= p1_3;
        mrd3 <= p2_3;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req = 1'b0; wen = 1'b1; add = 10'h0; be = 4'h0; data = 32'h0; id = 8'h0; user = 2'h0;
        clear = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        be = 4'hF;
        @(negedge clk);
        n_tests++;
        if ({rv1, rid1, ru1, rd1} !== 43'h0) begin
            n_fail++; $display("FAIL reset_resp got %h expected 0", {rv1, rid1, ru1, rd1});
        end
        n_tests++;
        if ({gnt1, msl1, mreq1, mbe1} !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_ctrl got %b expected 1000000", {gnt1, msl1, mreq1, mbe1});
        end
        tick();
    endtask

    task automatic test_write_read;
        logic        ev;
        logic [7:0]  eid;
        logic [31:0] ed;
        do_reset();
        for (int i = 0; i <= 3 + XL; i++) begin
            idle_inputs();
            add = 10'h010;
            if (i == 0) begin req = 1'b1; wen = 1'b0; data = 32'hDEADBEEF; be = 4'hF; id = 8'h05; end
            if (i == 2) begin req = 1'b1; wen = 1'b1; be = 4'hF; id = 8'h06; end
            @(negedge clk);
            if (i == 0) begin
                n_tests++;
                if ({gnt1, mreq1, mwe1, maddr1, mwd1, mbe1} !== {3'b111, 10'h010, 32'hDEADBEEF, 4'hF}) begin
                    n_fail++; $display("FAIL wr_pins got %b%b%b %h %h %h expected 111 010 deadbeef f",
                                       gnt1, mreq1, mwe1, maddr1, mwd1, mbe1);
                end
            end
            if (i == 2) begin
                n_tests++;
                if ({mreq1, mwe1} !== 2'b10) begin
                    n_fail++; $display("FAIL rd_pins got %b expected 10", {mreq1, mwe1});
                end
            end
            ev  = (i == 1 + XL) || (i == 3 + XL);
            eid = (i == 1 + XL) ? 8'h05 : ((i == 3 + XL) ? 8'h06 : 8'h00);
            ed  = (i == 3 + XL) ? 32'hDEADBEEF : 32'h0;
            n_tests++;
            if ({rv1, rid1, ru1, rd1} !== {ev, eid, 2'b00, ed}) begin
                n_fail++; $display("FAIL wr_rd_resp cyc=%0d got %b %h %h %h expected %b %h 0 %h",
                                   i, rv1, rid1, ru1, rd1, ev, eid, ed);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic        ev;
        logic [7:0]  eid;
        logic [1:0]  eu;
        logic [31:0] ed;
        int          k;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req = 1'b1; wen = 1'b0; add = 10'(i); data = 32'hA000_0000 + 32'(i); be = 4'hF;
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        for (int c = 0; c < 8 + 3 + XL + 2; c++) begin
            idle_inputs();
            if (c < 8) begin
                req = 1'b1; wen = 1'b1; add = 10'(c); id = 8'(c); user = 2'(c);
            end
            @(negedge clk);
            if (c < 8) begin
                n_tests++;
                if (gnt3 !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_gnt cyc=%0d got %b expected 1", c, gnt3);
                end
            end
            k   = c - (3 + XL);
            ev  = (k >= 0) && (k < 8);
            eid = ev ? 8'(k) : 8'h00;
            eu  = ev ? 2'(k) : 2'b00;
            ed  = ev ? (32'hA000_0000 + 32'(k)) : 32'h0;
            n_tests++;
            if ({rv3, rid3, ru3, rd3} !== {ev, eid, eu, ed}) begin
                n_fail++; $display("FAIL b2b_resp cyc=%0d got %b %h %h %h expected %b %h %h %h",
                                   c, rv3, rid3, ru3, rd3, ev, eid, eu, ed);
            end
            tick();
        end
    endtask

    task automatic test_sleep_wake;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            n_tests++;
            if ({msl1, gnt1} !== {(k == 17), (k != 17)}) begin
                n_fail++; $display("FAIL sleep_entry cyc=%0d got sleep=%b gnt=%b", k, msl1, gnt1);
            end
            tick();
        end
        req = 1'b1; wen = 1'b1; add = 10'h010; be = 4'hF; id = 8'h09;
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            n_tests++;
            if ({msl1, gnt1} !== {(j == 0), (j == 3)}) begin
                n_fail++; $display("FAIL wake cyc=%0d got sleep=%b gnt=%b expected %b %b",
                                   j, msl1, gnt1, (j == 0), (j == 3));
            end
            tick();
        end
        idle_inputs();
        for (int j = 0; j <= XL; j++) begin
            @(negedge clk);
            n_tests++;
            if ((j == XL) && ({rv1, rid1, rd1} !== {1'b1, 8'h09, 32'hDEADBEEF})) begin
                n_fail++; $display("FAIL wake_resp got %b %h %h expected 1 09 deadbeef", rv1, rid1, rd1);
            end else if ((j != XL) && (rv1 !== 1'b0)) begin
                n_fail++; $display("FAIL wake_resp_early got %b expected 0", rv1);
            end
            tick();
        end
    endtask

    task automatic test_clear;
        do_reset();
        for (int c = 0; c <= 2; c++) begin
            req = 1'b1; wen = 1'b1; add = 10'(c); be = 4'hF; id = 8'(c + 1); clear = (c == 2);
            @(negedge clk);
            if (c == 2) begin
                n_tests++;
                if ({gnt3, mreq3, rv3} !== 3'b110) begin
                    n_fail++; $display("FAIL clear_cycle got %b expected 110", {gnt3, mreq3, rv3});
                end
            end
            tick();
        end
        idle_inputs();
        for (int k = 3; k <= 20; k++) begin
            @(negedge clk);
            n_tests++;
            if ({rv3, msl3} !== {1'b0, (k >= 19)}) begin
                n_fail++; $display("FAIL clear_after cyc=%0d got valid=%b sleep=%b expected 0 %b",
                                   k, rv3, msl3, (k >= 19));
            end
            tick();
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int c = 0; c <= 1 + XL; c++) begin
            req = 1'b1; wen = 1'b1; add = 10'(c); be = 4'hF; id = 8'h20 + 8'(c);
            @(negedge clk);
            if (c < 1 + XL) tick();
        end
        n_tests++;
        if ({rv1, rid1} !== {1'b1, 8'h20}) begin
            n_fail++; $display("FAIL arst_pre got %b %h expected 1 20", rv1, rid1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rv1, rid1, rd1, gnt1} !== {1'b0, 8'h00, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL arst_resp got %b %h %h %b expected 0 00 0 1", rv1, rid1, rd1, gnt1);
        end
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({gnt1, rv1, msl1} !== 3'b100) begin
            n_fail++; $display("FAIL arst_release got %b expected 100", {gnt1, rv1, msl1});
        end
        for (int k = 2; k <= 17; k++) begin
            tick();
            @(negedge clk);
        end
        n_tests++;
        if (msl1 !== 1'b1) begin
            n_fail++; $display("FAIL arst_sleep_pre got %b expected 1", msl1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({msl1, gnt1} !== 2'b01) begin
            n_fail++; $display("FAIL arst_sleep got %b expected 01", {msl1, gnt1});
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_idle_after_resp;
        do_reset();
        req = 1'b1; wen = 1'b1; add = 10'h010; be = 4'hF; id = 8'h03;
        tick();
        idle_inputs();
        for (int k = 1; k <= 18 + XL; k++) begin
            @(negedge clk);
            n_tests++;
            if (msl1 !== (k == 18 + XL)) begin
                n_fail++; $display("FAIL idle_sleep cyc=%0d got %b expected %b", k, msl1, (k == 18 + XL));
            end
            if (k == 1 + XL) begin
                n_tests++;
                if ({rv1, rid1, rd1} !== {1'b1, 8'h03, 32'hDEADBEEF}) begin
                    n_fail++; $display("FAIL idle_resp got %b %h %h expected 1 03 deadbeef", rv1, rid1, rd1);
                end
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_sleep_wake();
        test_clear();
        test_async_reset();
        test_idle_after_resp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
